// File: rtl/laser_pkg.sv
// Shared constants and types for the multi-shot laser bank.
package laser_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [2:0] COLOR_LASER = 3'b110;

  typedef struct packed {
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
  } slot_t;

  typedef enum logic {
    SLOT_IDLE   = 1'b0,
    SLOT_FLYING = 1'b1
  } slot_state_e;

endpackage

// File: rtl/laser_slot.sv
// One projectile: spawns at the muzzle, climbs STEP px per tick, dies on kill or at the top.
// State is registered; hit is combinational from the registered position and the pixel counters.
module laser_slot
  import laser_pkg::*;
#(
  parameter int SHIP_Y = 440,
  parameter int SHOT_W = 2,
  parameter int SHOT_H = 8,
  parameter int STEP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       launch,
  input  logic       kill,
  input  logic       enable,
  input  logic [9:0] gunPosition,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hit
);

  localparam logic [9:0]  SPAWN_Y = 10'(SHIP_Y - SHOT_H);
  localparam logic [9:0]  STEP_V  = 10'(STEP);
  localparam logic [10:0] W_V     = 11'(SHOT_W);
  localparam logic [10:0] H_V     = 11'(SHOT_H);

  slot_state_e r_state, w_state_nxt;
  logic [9:0]  r_x, r_y, w_x_nxt, w_y_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SLOT_IDLE;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
    end
  end

  // Kill outranks movement; a launch is only ever offered to an idle slot.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    case (r_state)
      SLOT_IDLE: begin
        if (launch) begin
          w_state_nxt = SLOT_FLYING;
          w_x_nxt     = gunPosition;
          w_y_nxt     = SPAWN_Y;
        end
      end
      SLOT_FLYING: begin
        if (kill) begin
          w_state_nxt = SLOT_IDLE;
        end else if (enable) begin
          if (r_y < STEP_V) w_state_nxt = SLOT_IDLE;
          else              w_y_nxt     = r_y - STEP_V;
        end
      end
      default: w_state_nxt = SLOT_IDLE;
    endcase
  end

  logic [10:0] w_h, w_v, w_x11, w_y11;
  assign w_h   = {1'b0, hPos};
  assign w_v   = {1'b0, vPos};
  assign w_x11 = {1'b0, r_x};
  assign w_y11 = {1'b0, r_y};

  assign active = (r_state == SLOT_FLYING);
  assign x      = r_x;
  assign y      = r_y;
  assign hit    = active && (w_h >= w_x11) && (w_h < w_x11 + W_V)
                         && (w_v >= w_y11) && (w_v < w_y11 + H_V);

endmodule

// File: rtl/laser_bank.sv
// Pool of N_SHOTS laser projectiles with fire-edge launch, cooldown and dropped-shot pulse.
// Launch state appears 1 clk after the fire edge; colorLaser is 1 clk behind hPos/vPos.
module laser_bank
  import laser_pkg::*;
#(
  parameter int         N_SHOTS  = 4,
  parameter int         SHIP_Y   = 440,
  parameter int         SHOT_W   = 2,
  parameter int         SHOT_H   = 8,
  parameter int         STEP     = 4,
  parameter int         COOLDOWN = 6,
  parameter logic [2:0] COLOR    = COLOR_LASER
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fire,
  input  logic [9:0]            gunPosition,
  input  logic [N_SHOTS-1:0]    killingAlien,
  input  logic [9:0]            hPos,
  input  logic [9:0]            vPos,
  output logic [10*N_SHOTS-1:0] xLaser,
  output logic [10*N_SHOTS-1:0] yLaser,
  output logic [N_SHOTS-1:0]    activeMask,
  output logic                  dropped,
  output logic [2:0]            colorLaser
);

  localparam int              CD_W    = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

  logic            r_fire_q;
  logic [CD_W-1:0] r_cooldown;
  logic            r_dropped;
  logic [2:0]      r_color;

  logic               w_launch_req, w_accept, w_found;
  logic [N_SHOTS-1:0] w_free, w_launch_sel, w_hit;
  slot_t              w_slot [N_SHOTS];

  assign w_launch_req = fire & ~r_fire_q;
  // Registered mask only: a slot freed this cycle is not reusable until next cycle.
  assign w_free       = ~activeMask;

  always_comb begin
    w_launch_sel = '0;
    w_found      = 1'b0;
    for (int i = 0; i < N_SHOTS; i++) begin
      if (w_free[i] && !w_found) begin
        w_launch_sel[i] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

  assign w_accept = w_launch_req && (r_cooldown == '0) && w_found;

  for (genvar g = 0; g < N_SHOTS; g++) begin : g_slot
    laser_slot #(
      .SHIP_Y (SHIP_Y),
      .SHOT_W (SHOT_W),
      .SHOT_H (SHOT_H),
      .STEP   (STEP)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .launch      (w_accept & w_launch_sel[g]),
      .kill        (killingAlien[g]),
      .enable      (enable),
      .gunPosition (gunPosition),
      .hPos        (hPos),
      .vPos        (vPos),
      .active      (w_slot[g].active),
      .x           (w_slot[g].x),
      .y           (w_slot[g].y),
      .hit         (w_hit[g])
    );

    assign activeMask[g]       = w_slot[g].active;
    assign xLaser[10*g +: 10]  = w_slot[g].x;
    assign yLaser[10*g +: 10]  = w_slot[g].y;
  end

  // A launch reloads the cooldown and swallows any enable arriving with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fire_q   <= 1'b0;
      r_cooldown <= '0;
      r_dropped  <= 1'b0;
      r_color    <= '0;
    end else begin
      r_fire_q  <= fire;
      r_dropped <= w_launch_req & ~w_accept;
      if (w_accept)
        r_cooldown <= CD_LOAD;
      else if (enable && (r_cooldown != '0))
        r_cooldown <= r_cooldown - 1'b1;
      r_color <= (|w_hit) ? COLOR : 3'b000;
    end
  end

  assign dropped    = r_dropped;
  assign colorLaser = r_color;

endmodule

// File: tb/tb_laser_bank.sv
// Directed plus randomized bench for laser_bank against a cycle-level behavioural model.
module tb_laser_bank;

  localparam int N        = 4;
  localparam int SHOT_W   = 2;
  localparam int SHOT_H   = 8;
  localparam int STEP     = 4;
  localparam int COOLDOWN = 6;
  localparam int SPAWN    = 440 - 8;
  localparam int COLOR    = 6;

  logic            clk = 1'b0;
  logic            reset, enable, fire;
  logic [9:0]      gunPosition, hPos, vPos;
  logic [N-1:0]    killingAlien;
  logic [10*N-1:0] xLaser, yLaser;
  logic [N-1:0]    activeMask;
  logic            dropped;
  logic [2:0]      colorLaser;

  laser_bank dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fire         (fire),
    .gunPosition  (gunPosition),
    .killingAlien (killingAlien),
    .hPos         (hPos),
    .vPos         (vPos),
    .xLaser       (xLaser),
    .yLaser       (yLaser),
    .activeMask   (activeMask),
    .dropped      (dropped),
    .colorLaser   (colorLaser)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model state, as visible on the outputs after each edge.
  int m_act [N];
  int m_x   [N];
  int m_y   [N];
  int m_cd, m_prev_fire, m_dropped, m_color;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_cd = 0; m_prev_fire = 0; m_dropped = 0; m_color = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int sel = -1;
    int any_hit = 0;
    int req = (fire && !m_prev_fire) ? 1 : 0;
    for (int i = 0; i < N; i++)
      if (m_act[i] != 0 && hPos >= m_x[i] && hPos < m_x[i] + SHOT_W &&
          vPos >= m_y[i] && vPos < m_y[i] + SHOT_H)
        any_hit = 1;
    if (req != 0 && m_cd == 0)
      for (int i = N - 1; i >= 0; i--)
        if (m_act[i] == 0) sel = i;
    m_dropped = (req != 0 && sel < 0) ? 1 : 0;
    m_color   = any_hit != 0 ? COLOR : 0;
    for (int i = 0; i < N; i++) begin
      if (m_act[i] != 0) begin
        if (killingAlien[i]) m_act[i] = 0;
        else if (enable) begin
          if (m_y[i] < STEP) m_act[i] = 0;
          else               m_y[i]   = m_y[i] - STEP;
        end
      end else if (i == sel) begin
        m_act[i] = 1; m_x[i] = gunPosition; m_y[i] = SPAWN;
      end
    end
    if (sel >= 0)                 m_cd = COOLDOWN;
    else if (enable && m_cd > 0)  m_cd = m_cd - 1;
    m_prev_fire = fire ? 1 : 0;
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("active%0d", i), 64'(activeMask[i]), 64'(m_act[i]));
      check($sformatf("x%0d", i), 64'(xLaser[10*i +: 10]), 64'(m_x[i]));
      check($sformatf("y%0d", i), 64'(yLaser[10*i +: 10]), 64'(m_y[i]));
    end
    check("dropped", 64'(dropped), 64'(m_dropped));
    check("color", 64'(colorLaser), 64'(m_color));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic en_ticks(input int n);
    enable = 1'b1;
    repeat (n) tick();
    enable = 1'b0;
  endtask

  task automatic press(input logic [9:0] gx);
    gunPosition = gx;
    fire = 1'b1;
    tick();
    fire = 1'b0;
    tick();
  endtask

  initial begin
    int k, y1_before;
    reset = 1'b1; enable = 1'b0; fire = 1'b0; gunPosition = '0;
    killingAlien = '0; hPos = '0; vPos = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_mask", 64'(activeMask), 64'd0);
    check("rst_x", 64'(xLaser), 64'd0);
    check("rst_y", 64'(yLaser), 64'd0);
    check("rst_dropped", 64'(dropped), 64'd0);
    check("rst_color", 64'(colorLaser), 64'd0);
    reset = 1'b0;
    tick();

    // First launch.
    gunPosition = 10'd100; fire = 1'b1;
    tick();
    check("launch_mask", 64'(activeMask), 64'b0001);
    check("launch_x0", 64'(xLaser[9:0]), 64'd100);
    check("launch_y0", 64'(yLaser[9:0]), 64'd432);
    fire = 1'b0;
    tick();

    // Movement and render.
    en_ticks(3);
    check("move_y0", 64'(yLaser[9:0]), 64'd420);
    hPos = 10'd101; vPos = 10'd420;
    tick();
    check("render_on", 64'(colorLaser), 64'(3'b110));
    hPos = 10'd102;
    tick();
    check("render_off", 64'(colorLaser), 64'd0);

    // Cooldown still 3: press is dropped.
    fire = 1'b1;
    tick();
    check("cd_dropped", 64'(dropped), 64'd1);
    check("cd_mask", 64'(activeMask), 64'b0001);
    fire = 1'b0;
    tick();
    check("cd_dropped_once", 64'(dropped), 64'd0);
    en_ticks(3);
    press(10'd300);
    check("cd_expired_mask", 64'(activeMask), 64'b0011);

    // Kill slot 0 with enable and a fire edge in the same cycle.
    en_ticks(6);
    y1_before = int'(yLaser[19:10]);
    killingAlien = 4'b0001; enable = 1'b1; fire = 1'b1; gunPosition = 10'd50;
    tick();
    check("kill_mask", 64'(activeMask), 64'b0110);
    check("kill_y1", 64'(yLaser[19:10]), 64'(y1_before - 4));
    check("kill_x2", 64'(xLaser[29:20]), 64'd50);
    killingAlien = '0; enable = 1'b0; fire = 1'b0;
    tick();

    // Fill the pool, then overflow.
    en_ticks(7);
    press(10'd1022);
    check("fill3_mask", 64'(activeMask), 64'b0111);
    en_ticks(7);
    press(10'd7);
    check("fill4_mask", 64'(activeMask), 64'b1111);
    en_ticks(7);
    fire = 1'b1;
    tick();
    check("full_dropped", 64'(dropped), 64'd1);
    check("full_mask", 64'(activeMask), 64'b1111);
    fire = 1'b0;
    tick();

    // Fly everything off the top edge.
    en_ticks(120);
    check("top_mask", 64'(activeMask), 64'd0);
    check("top_y0", 64'(yLaser[9:0]), 64'd0);
    check("top_y3", 64'(yLaser[39:30]), 64'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      fire        = ($urandom_range(0, 2) == 0);
      enable      = ($urandom_range(0, 3) == 0);
      gunPosition = 10'($urandom);
      for (int i = 0; i < N; i++) killingAlien[i] = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 1) == 0) begin
        k    = int'($urandom_range(0, N - 1));
        hPos = 10'(m_x[k] + int'($urandom_range(0, 3)) - 1);
        vPos = 10'(m_y[k] + int'($urandom_range(0, 9)) - 1);
      end else begin
        hPos = 10'($urandom);
        vPos = 10'($urandom);
      end
      tick();
    end
    fire = 1'b0; enable = 1'b0; killingAlien = '0;
    tick();

    // Asynchronous reset with a shot in flight.
    en_ticks(7);
    en_ticks(120);
    press(10'd200);
    check("pre_rst_mask", 64'(activeMask), 64'b0001);
    reset = 1'b1;
    #2;
    check("arst_mask", 64'(activeMask), 64'd0);
    check("arst_x", 64'(xLaser), 64'd0);
    check("arst_y", 64'(yLaser), 64'd0);
    check("arst_dropped", 64'(dropped), 64'd0);
    check("arst_color", 64'(colorLaser), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
